// File: rtl/uart_io_port_if.sv
// Processor-side I/O bus for the UART port: port ID, write data/strobe, read strobe/data.
// Latency: read data is combinational from the port ID; writes act on the strobed edge.
// Backpressure: none; the processor polls STATUS before writing or reading.
interface uart_io_port_if;
  logic [7:0] IO_port_ID;
  logic [7:0] IO_write_data;
  logic       IO_write_strobe;
  logic       IO_read_strobe;
  logic [7:0] IO_read_data;

  modport master (
    output IO_port_ID, IO_write_data, IO_write_strobe, IO_read_strobe,
    input  IO_read_data
  );

  modport slave (
    input  IO_port_ID, IO_write_data, IO_write_strobe, IO_read_strobe,
    output IO_read_data
  );
endinterface

// File: rtl/uart_io_port.sv
// Byte FIFO used for the TX and RX queues; pointers wrap modulo DEPTH.
// Latency: head visible combinationally; push/pop take effect at the clock edge.
// Backpressure: caller qualifies push/pop against the count (no internal guard).
module uart_io_port_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [7:0]    i_dat,
  input  logic          i_pop,
  output logic [7:0]    o_dat,
  output logic [AW:0]   o_cnt
);
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_cnt;

  // Storage array; contents are don't-care while the count says empty.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_dat;
  end

  // Pointer and occupancy bookkeeping; push+pop together leaves the count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_dat = r_mem[r_rd_ptr];
  assign o_cnt = r_cnt;
endmodule

// UART I/O port: TX_DATA/STATUS/RX_DATA registers over a processor strobe bus, 8N1 serial.
// Latency: TX start bit begins one edge after the byte is queued; RX byte lands at stop mid-bit.
// Backpressure: full TX FIFO drops writes; full RX FIFO drops frames and sets rx_overrun.
module uart_io_port #(
  parameter int         CLKS_PER_BIT = 868,
  parameter int         FIFO_DEPTH   = 4,
  parameter logic [7:0] BASE_ID      = 8'h00
) (
  input  logic           clk100,
  input  logic           reset,
  uart_io_port_if.slave  io,
  input  logic           uart_rx,
  output logic           uart_tx
);
  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT  = (AW+1)'(FIFO_DEPTH);
  localparam logic [11:0] BIT_LAST  = 12'(CLKS_PER_BIT - 1);
  localparam logic [11:0] HALF_LAST = 12'(CLKS_PER_BIT / 2 - 1);
  localparam logic [7:0]  ID_STATUS = BASE_ID + 8'd1;
  localparam logic [7:0]  ID_RX     = BASE_ID + 8'd2;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t      r_tx_state, r_rx_state;
  logic [11:0] r_tx_cnt, r_rx_cnt;
  logic [2:0]  r_tx_bit, r_rx_bit;
  logic [7:0]  r_tx_shift, r_rx_shift;
  logic        r_tx_line;
  logic        r_rx_s1, r_rx_s2, r_rx_prev;
  logic        r_overrun, r_frame_err;

  logic [7:0]  w_tx_head, w_rx_head, w_status;
  logic [AW:0] w_tx_cnt, w_rx_cnt;
  logic        w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
  logic        w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic        w_rx_stop_mid, w_status_wr;

  assign w_tx_full  = (w_tx_cnt == FULL_CNT);
  assign w_tx_empty = (w_tx_cnt == '0);
  assign w_rx_full  = (w_rx_cnt == FULL_CNT);
  assign w_rx_empty = (w_rx_cnt == '0);

  // Serializer takes a byte when idle, or straight from STOP for back-to-back frames.
  assign w_tx_pop  = !w_tx_empty &&
                     ((r_tx_state == S_IDLE) || ((r_tx_state == S_STOP) && (r_tx_cnt == BIT_LAST)));
  assign w_tx_push = io.IO_write_strobe && (io.IO_port_ID == BASE_ID) && (!w_tx_full || w_tx_pop);

  assign w_rx_pop      = io.IO_read_strobe && (io.IO_port_ID == ID_RX) && !w_rx_empty;
  assign w_rx_stop_mid = (r_rx_state == S_STOP) && (r_rx_cnt == BIT_LAST);
  assign w_rx_push     = w_rx_stop_mid && r_rx_s2 && (!w_rx_full || w_rx_pop);
  assign w_status_wr   = io.IO_write_strobe && (io.IO_port_ID == ID_STATUS);

  uart_io_port_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk100), .rst(reset), .i_push(w_tx_push), .i_dat(io.IO_write_data),
    .i_pop(w_tx_pop), .o_dat(w_tx_head), .o_cnt(w_tx_cnt)
  );

  uart_io_port_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk100), .rst(reset), .i_push(w_rx_push), .i_dat(r_rx_shift),
    .i_pop(w_rx_pop), .o_dat(w_rx_head), .o_cnt(w_rx_cnt)
  );

  assign w_status = {1'b0, r_frame_err, (r_tx_state != S_IDLE), r_overrun,
                     w_rx_full, !w_rx_empty, w_tx_empty, w_tx_full};

  // Read mux: RX head (zero when empty), status byte, or zero for unmapped IDs.
  always_comb begin
    io.IO_read_data = 8'h00;
    if (io.IO_port_ID == ID_RX) begin
      if (!w_rx_empty) io.IO_read_data = w_rx_head;
    end else if (io.IO_port_ID == ID_STATUS) begin
      io.IO_read_data = w_status;
    end
  end

  // TX serializer: start, 8 data bits LSB first, stop; line level is registered.
  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) begin
      r_tx_state <= S_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx_line  <= 1'b1;
    end else begin
      case (r_tx_state)
        S_IDLE: begin
          if (w_tx_pop) begin
            r_tx_state <= S_START;
            r_tx_shift <= w_tx_head;
            r_tx_line  <= 1'b0;
            r_tx_cnt   <= '0;
          end
        end
        S_START: begin
          if (r_tx_cnt == BIT_LAST) begin
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_state <= S_DATA;
            r_tx_line  <= r_tx_shift[0];
          end else begin
            r_tx_cnt <= r_tx_cnt + 12'd1;
          end
        end
        S_DATA: begin
          if (r_tx_cnt == BIT_LAST) begin
            r_tx_cnt <= '0;
            if (r_tx_bit == 3'd7) begin
              r_tx_state <= S_STOP;
              r_tx_line  <= 1'b1;
            end else begin
              r_tx_bit   <= r_tx_bit + 3'd1;
              r_tx_shift <= r_tx_shift >> 1;
              r_tx_line  <= r_tx_shift[1];
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + 12'd1;
          end
        end
        S_STOP: begin
          if (r_tx_cnt == BIT_LAST) begin
            r_tx_cnt <= '0;
            if (w_tx_pop) begin
              r_tx_state <= S_START;
              r_tx_shift <= w_tx_head;
              r_tx_line  <= 1'b0;
            end else begin
              r_tx_state <= S_IDLE;
              r_tx_line  <= 1'b1;
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + 12'd1;
          end
        end
        default: r_tx_state <= S_IDLE;
      endcase
    end
  end

  assign uart_tx = r_tx_line;

  // Two-flop synchronizer plus a delayed copy for falling-edge detection; idle-high on reset.
  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_s1   <= uart_rx;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
    end
  end

  // RX deserializer: half-bit start check rejects glitches, then mid-bit sampling.
  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) begin
      r_rx_state <= S_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else begin
      case (r_rx_state)
        S_IDLE: begin
          r_rx_cnt <= '0;
          if (r_rx_prev && !r_rx_s2) r_rx_state <= S_START;
        end
        S_START: begin
          if (r_rx_cnt == HALF_LAST) begin
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_state <= r_rx_s2 ? S_IDLE : S_DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + 12'd1;
          end
        end
        S_DATA: begin
          if (r_rx_cnt == BIT_LAST) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
            if (r_rx_bit == 3'd7) r_rx_state <= S_STOP;
            else                  r_rx_bit   <= r_rx_bit + 3'd1;
          end else begin
            r_rx_cnt <= r_rx_cnt + 12'd1;
          end
        end
        S_STOP: begin
          if (r_rx_cnt == BIT_LAST) begin
            r_rx_cnt   <= '0;
            r_rx_state <= S_IDLE;
          end else begin
            r_rx_cnt <= r_rx_cnt + 12'd1;
          end
        end
        default: r_rx_state <= S_IDLE;
      endcase
    end
  end

  // Sticky error flags: a STATUS write clears them, a same-cycle new error still sets.
  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_status_wr) begin
        r_overrun   <= 1'b0;
        r_frame_err <= 1'b0;
      end
      if (w_rx_stop_mid && r_rx_s2 && w_rx_full && !w_rx_pop) r_overrun   <= 1'b1;
      if (w_rx_stop_mid && !r_rx_s2)                           r_frame_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_uart_io_port.sv
// Bench for uart_io_port with CLKS_PER_BIT=4, FIFO_DEPTH=4, BASE_ID=0.
// Register table, directed multi-cycle sequences, then randomized RX/TX against a queue model.
// Serial TX output is decoded independently into a byte queue with frame start times.
module tb_uart_io_port;
  localparam int CPB = 4;

  logic clk100  = 1'b0;
  logic reset   = 1'b1;
  logic uart_rx = 1'b1;
  logic uart_tx;

  uart_io_port_if bus();

  uart_io_port #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .BASE_ID(8'h00)) dut (
    .clk100 (clk100),
    .reset  (reset),
    .io     (bus),
    .uart_rx(uart_rx),
    .uart_tx(uart_tx)
  );

  always #5 clk100 = ~clk100;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [7:0] tx_got[$];
  int         tx_st[$];

  always @(posedge clk100) cyc++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Independent serial decoder: sample every negedge, mid-bit at offset 2 of each 4-cycle bit.
  initial begin
    logic [7:0] b;
    int st;
    forever begin
      @(negedge clk100);
      if (uart_tx === 1'b0) begin
        st = cyc;
        repeat (2) @(negedge clk100);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk100);
          b[i] = uart_tx;
        end
        repeat (CPB) @(negedge clk100);
        tx_got.push_back(b);
        tx_st.push_back(st);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk100);
  endtask

  task automatic io_write(input logic [7:0] id, input logic [7:0] d);
    bus.IO_port_ID      = id;
    bus.IO_write_data   = d;
    bus.IO_write_strobe = 1'b1;
    @(negedge clk100);
    bus.IO_write_strobe = 1'b0;
  endtask

  task automatic io_read(input logic [7:0] id, output logic [7:0] d);
    bus.IO_port_ID     = id;
    bus.IO_read_strobe = 1'b1;
    #1 d = bus.IO_read_data;
    @(negedge clk100);
    bus.IO_read_strobe = 1'b0;
  endtask

  task automatic peek(input logic [7:0] id, output logic [7:0] d);
    bus.IO_port_ID = id;
    #1 d = bus.IO_read_data;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int gap);
    uart_rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      tick(CPB);
    end
    uart_rx = stop_bit;
    tick(CPB);
    uart_rx = 1'b1;
    tick(gap);
  endtask

  task automatic do_reset;
    bus.IO_write_strobe = 1'b0;
    bus.IO_read_strobe  = 1'b0;
    uart_rx = 1'b1;
    reset   = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(2);
  endtask

  typedef struct {
    int         op;   // 0 peek, 1 read strobe, 2 write then peek STATUS, 3 wait a cycle then peek
    logic [7:0] id;
    logic [7:0] dat;
    logic [7:0] exp;
  } vec_t;

  vec_t vt[12];

  initial begin
    logic [7:0]  d;
    logic [39:0] got_w, exp_w;
    logic        busy_all, gaps_ok;
    logic [7:0]  bytes[6];
    logic [7:0]  a5;
    logic [7:0]  mq[$];
    logic        m_ovr, m_fe;
    int          k;

    bus.IO_port_ID      = 8'h00;
    bus.IO_write_data   = 8'h00;
    bus.IO_write_strobe = 1'b0;
    bus.IO_read_strobe  = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(2);

    // ---------------- register table ----------------
    vt[0]  = '{0, 8'h01, 8'h00, 8'h02};
    vt[1]  = '{0, 8'h00, 8'h00, 8'h00};
    vt[2]  = '{0, 8'h02, 8'h00, 8'h00};
    vt[3]  = '{0, 8'h03, 8'h00, 8'h00};
    vt[4]  = '{0, 8'hFF, 8'h00, 8'h00};
    vt[5]  = '{1, 8'h02, 8'h00, 8'h00};
    vt[6]  = '{2, 8'h05, 8'h55, 8'h02};
    vt[7]  = '{2, 8'h01, 8'hFF, 8'h02};
    vt[8]  = '{2, 8'h02, 8'h12, 8'h02};
    vt[9]  = '{1, 8'h01, 8'h00, 8'h02};
    vt[10] = '{2, 8'h00, 8'h81, 8'h00};
    vt[11] = '{3, 8'h01, 8'h00, 8'h22};
    for (int i = 0; i < 12; i++) begin
      case (vt[i].op)
        0: peek(vt[i].id, d);
        1: io_read(vt[i].id, d);
        2: begin io_write(vt[i].id, vt[i].dat); peek(8'h01, d); end
        default: begin tick(1); peek(vt[i].id, d); end
      endcase
      check($sformatf("vec%0d", i), d, vt[i].exp);
    end
    tick(50);
    tx_got.delete(); tx_st.delete();

    // ---------------- TX waveform for 0xA5 ----------------
    a5 = 8'hA5;
    io_write(8'h00, a5);
    busy_all = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk100);
      got_w[i] = uart_tx;
      exp_w[i] = (i < 4) ? 1'b0 : (i < 36) ? a5[(i - 4) / 4] : 1'b1;
      peek(8'h01, d);
      busy_all = busy_all & d[5];
    end
    check("tx_a5_wave", got_w, exp_w);
    check("tx_a5_busy", busy_all, 1'b1);
    @(negedge clk100);
    peek(8'h01, d);
    check("tx_a5_status_after", d, 8'h02);
    check("tx_a5_line_idle", uart_tx, 1'b1);
    tick(5);
    check("tx_a5_decoded", (tx_got.size() == 1) ? tx_got[0] : 8'hxx, 8'hA5);
    tx_got.delete(); tx_st.delete();

    // ---------------- RX single frame 0x3C ----------------
    send_frame(8'h3C, 1'b1, 2);
    peek(8'h01, d);
    check("rx_3c_status", d, 8'h06);
    io_read(8'h02, d);
    check("rx_3c_data", d, 8'h3C);
    peek(8'h01, d);
    check("rx_3c_status_empty", d, 8'h02);

    // ---------------- TX six-byte burst ----------------
    for (int i = 0; i < 6; i++) bytes[i] = 8'($urandom);
    for (int i = 0; i < 6; i++) io_write(8'h00, bytes[i]);
    tick(5 * 40 + 20);
    check("burst_count", tx_got.size(), 5);
    for (int i = 0; i < 5 && i < tx_got.size(); i++)
      check($sformatf("burst_byte%0d", i), tx_got[i], bytes[i]);
    gaps_ok = 1'b1;
    for (int i = 1; i < tx_st.size(); i++)
      if (tx_st[i] - tx_st[i-1] != 40) gaps_ok = 1'b0;
    check("burst_no_gaps", gaps_ok, 1'b1);
    tx_got.delete(); tx_st.delete();

    // ---------------- RX overrun, status clear, full push+pop ----------------
    for (int i = 0; i < 5; i++) begin
      bytes[i] = 8'(8'h40 + i * 8'h11);
      send_frame(bytes[i], 1'b1, 2);
    end
    peek(8'h01, d);
    check("ovr_status", d, 8'h1E);
    bus.IO_port_ID      = 8'h01;
    bus.IO_write_data   = 8'($urandom);
    bus.IO_write_strobe = 1'b1;
    bus.IO_read_strobe  = 1'b1;
    #1 d = bus.IO_read_data;
    @(negedge clk100);
    bus.IO_write_strobe = 1'b0;
    bus.IO_read_strobe  = 1'b0;
    check("ovr_status_same_cycle", d, 8'h1E);
    peek(8'h01, d);
    check("ovr_cleared", d, 8'h0E);
    bytes[5] = 8'hC3;
    send_frame(bytes[5], 1'b1, 0);
    io_read(8'h02, d);
    check("full_pop_data", d, bytes[0]);
    tick(2);
    peek(8'h01, d);
    check("full_push_pop_status", d, 8'h0E);
    for (int i = 1; i < 5; i++) begin
      io_read(8'h02, d);
      check($sformatf("drain%0d", i), d, (i < 4) ? bytes[i] : bytes[5]);
    end
    peek(8'h01, d);
    check("drain_status", d, 8'h02);

    // ---------------- frame error and glitch ----------------
    send_frame(8'h5A, 1'b0, 2);
    peek(8'h01, d);
    check("ferr_status", d, 8'h42);
    io_write(8'h01, 8'h00);
    peek(8'h01, d);
    check("ferr_cleared", d, 8'h02);
    uart_rx = 1'b0;
    tick(1);
    uart_rx = 1'b1;
    tick(50);
    peek(8'h01, d);
    check("glitch_ignored", d, 8'h02);

    // ---------------- RX reset mid-frame ----------------
    uart_rx = 1'b0;
    tick(CPB);
    uart_rx = 1'b1;
    tick(CPB * 3);
    do_reset();
    tick(50);
    peek(8'h01, d);
    check("rx_reset_midframe", d, 8'h02);

    // ---------------- TX reset during data bit 3 ----------------
    io_write(8'h00, 8'hF7);
    tick(18);
    check("tx_bit3_low", uart_tx, 1'b0);
    #2 reset = 1'b1;
    #1 check("tx_reset_immediate", uart_tx, 1'b1);
    tick(3);
    reset = 1'b0;
    tick(2);
    peek(8'h01, d);
    check("tx_reset_status", d, 8'h02);
    tick(50);
    tx_got.delete(); tx_st.delete();

    // ---------------- randomized RX against queue model ----------------
    do_reset();
    m_ovr = 1'b0;
    m_fe  = 1'b0;
    for (int it = 0; it < 40; it++) begin
      k = $urandom_range(0, 9);
      if (k < 4) begin
        logic [7:0] b;
        logic       sb;
        b  = 8'($urandom);
        sb = ($urandom_range(0, 7) != 0);
        send_frame(b, sb, $urandom_range(2, 4));
        if (!sb)               m_fe = 1'b1;
        else if (mq.size() < 4) mq.push_back(b);
        else                    m_ovr = 1'b1;
      end else if (k < 7) begin
        io_read(8'h02, d);
        check($sformatf("rand_rd%0d", it), d, (mq.size() != 0) ? mq[0] : 8'h00);
        if (mq.size() != 0) void'(mq.pop_front());
      end else if (k < 9) begin
        peek(8'h01, d);
        check($sformatf("rand_st%0d", it), d,
              {1'b0, m_fe, 1'b0, m_ovr, (mq.size() == 4), (mq.size() != 0), 1'b1, 1'b0});
      end else begin
        io_write(8'h01, 8'($urandom));
        m_ovr = 1'b0;
        m_fe  = 1'b0;
      end
    end
    peek(8'h01, d);
    check("rand_final_status", d,
          {1'b0, m_fe, 1'b0, m_ovr, (mq.size() == 4), (mq.size() != 0), 1'b1, 1'b0});

    // ---------------- randomized TX bursts ----------------
    for (int bi = 0; bi < 3; bi++) begin
      int n;
      int nexp;
      logic [7:0] sent[$];
      n = $urandom_range(1, 6);
      nexp = (n < 5) ? n : 5;
      tx_got.delete(); tx_st.delete();
      for (int i = 0; i < n; i++) begin
        sent.push_back(8'($urandom));
        io_write(8'h00, sent[i]);
      end
      tick(nexp * 40 + 20);
      check($sformatf("rburst%0d_count", bi), tx_got.size(), nexp);
      for (int i = 0; i < nexp && i < tx_got.size(); i++)
        check($sformatf("rburst%0d_b%0d", bi, i), tx_got[i], sent[i]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
